// File: rtl/cpu_types.sv
// Shared CPU scalar and record types used by the branch-predictor update path.
package cpu_types;
  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    logic  outcome;
    word_t target;
  } btb_upd_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at rr_ptr; the pointer
// moves past the winner only when the caller reports the grant was consumed.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr, ptr_nxt;

  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    gnt     = '0;
    ptr_nxt = rr_ptr;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(rr_ptr) + off) % NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        ptr_nxt  = PW'((idx + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)          rr_ptr <= '0;
    else if (advance) rr_ptr <= ptr_nxt;
  end
endmodule

// File: rtl/btb_update_arbiter.sv
// Funnels resolved branches from several requesters into an in-order queue that
// drains one BTB update per cycle.
module btb_update_arbiter
  import cpu_types::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        req_valid,
  input  word_t [NREQ-1:0]       req_pc,
  input  logic [NREQ-1:0]        req_outcome,
  input  word_t [NREQ-1:0]       req_target,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   flush,
  input  logic                   pop_hold,
  output logic                   update_btb,
  output word_t                  update_pc,
  output logic                   branch_outcome,
  output word_t                  branch_target,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  btb_upd_t      q [DEPTH];
  logic [AW-1:0] head, tail;
  logic [NREQ-1:0] gnt;
  logic          can_acc, push, pop;
  btb_upd_t      push_e, head_e;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req_valid),
    .advance (push),
    .gnt     (gnt)
  );

  assign can_acc   = (count < FULL) && !flush;
  assign req_ready = gnt & {NREQ{can_acc}};
  assign push      = (|req_ready) && !RST;
  // pop_hold models a stalled BTB so the queue can be prefilled
  assign pop       = (count != '0) && !pop_hold && !flush;

  always_comb begin
    push_e = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) push_e = '{pc: req_pc[i], outcome: req_outcome[i], target: req_target[i]};
  end

  assign head_e         = (count != '0) ? q[head] : '0;
  assign update_btb     = pop;
  assign update_pc      = head_e.pc;
  assign branch_outcome = head_e.outcome;
  assign branch_target  = head_e.target;

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (push) q[tail] <= push_e;
  end
endmodule

// File: tb/tb_btb_update_arbiter.sv
// Directed scoreboard bench: expected BTB updates are queued at acceptance and
// a negedge monitor compares them as they leave the DUT.
module tb_btb_update_arbiter;
  import cpu_types::*;
  localparam int NREQ = 2, DEPTH = 4;

  logic CLK = 1'b0, RST = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_outcome = '0, req_ready;
  word_t [NREQ-1:0] req_pc = '0, req_target = '0;
  logic flush = 1'b0, pop_hold = 1'b0, update_btb, branch_outcome;
  word_t update_pc, branch_target;
  logic [$clog2(DEPTH):0] count;

  int checks = 0, failures = 0;
  btb_upd_t exp_q[$];

  btb_update_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_pc(req_pc),
    .req_outcome(req_outcome), .req_target(req_target), .req_ready(req_ready),
    .flush(flush), .pop_hold(pop_hold), .update_btb(update_btb),
    .update_pc(update_pc), .branch_outcome(branch_outcome),
    .branch_target(branch_target), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input int i, input word_t pc, input logic o, input word_t t);
    req_pc[i] = pc; req_outcome[i] = o; req_target[i] = t;
  endtask

  task automatic expect_upd(input word_t pc, input logic o, input word_t t);
    exp_q.push_back('{pc: pc, outcome: o, target: t});
  endtask

  // monitor: every strobed update must match the oldest outstanding acceptance
  always @(negedge CLK) begin
    if (!RST && update_btb === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_update: got pc %0h expected no update", update_pc);
      end else begin
        btb_upd_t e;
        e = exp_q.pop_front();
        chk("upd_pc", update_pc, e.pc);
        chk("upd_outcome", 32'(branch_outcome), 32'(e.outcome));
        chk("upd_target", branch_target, e.target);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_count", 32'(count), 0);
    chk("rst_update", 32'(update_btb), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_pc_zero", update_pc, 0);

    // single request, one-cycle latency
    cyc(); put(0, 32'h100, 1'b1, 32'h200); req_valid = 2'b01;
    @(negedge CLK); chk("t1_ready", 32'(req_ready), 32'h1); expect_upd(32'h100, 1'b1, 32'h200);
    cyc(); req_valid = 2'b00;
    @(negedge CLK); chk("t1_upd", 32'(update_btb), 1); chk("t1_count", 32'(count), 1);
    cyc();
    @(negedge CLK); chk("t1_idle_upd", 32'(update_btb), 0); chk("t1_idle_count", 32'(count), 0);
    chk("t1_idle_pc", update_pc, 0); chk("t1_idle_tgt", branch_target, 0);

    // only req1 valid while the pointer favours it, then keeps being granted
    for (int k = 0; k < 3; k++) begin
      cyc(); put(1, 32'h30 + k, 1'b0, 32'h300 + k); req_valid = 2'b10;
      @(negedge CLK);
      chk("solo1_ready", 32'(req_ready), 32'h2);
      chk("solo1_count", 32'(count), (k == 0) ? 0 : 1);
      chk("solo1_upd", 32'(update_btb), (k == 0) ? 0 : 1);
      expect_upd(32'h30 + k, 1'b0, 32'h300 + k);
    end
    cyc(); req_valid = 2'b00;
    @(negedge CLK); chk("solo1_drain", 32'(update_btb), 1);

    // both valid: alternating grants
    put(0, 32'h10, 1'b1, 32'h110); put(1, 32'h20, 1'b0, 32'h220);
    for (int k = 0; k < 4; k++) begin
      cyc(); req_valid = 2'b11;
      @(negedge CLK);
      if (k % 2 == 0) begin chk("alt_ready0", 32'(req_ready), 32'h1); expect_upd(32'h10, 1'b1, 32'h110); end
      else            begin chk("alt_ready1", 32'(req_ready), 32'h2); expect_upd(32'h20, 1'b0, 32'h220); end
    end
    cyc(); req_valid = 2'b00;

    // steady one-in-one-out
    for (int k = 0; k < 5; k++) begin
      cyc(); put(0, 32'h40 + k, k[0], 32'h440 + k); req_valid = 2'b01;
      @(negedge CLK);
      chk("steady_ready", 32'(req_ready), 32'h1);
      chk("steady_count", 32'(count), (k == 0) ? 0 : 1);
      expect_upd(32'h40 + k, k[0], 32'h440 + k);
    end
    cyc(); req_valid = 2'b00;

    // prefill to full with the pop stalled
    for (int k = 0; k < 4; k++) begin
      cyc(); pop_hold = 1'b1; put(0, 32'h50 + k, k[0], 32'h550 + k); req_valid = 2'b01;
      @(negedge CLK);
      chk("fill_ready", 32'(req_ready), 32'h1);
      chk("fill_count", 32'(count), k);
      chk("fill_upd", 32'(update_btb), 0);
      expect_upd(32'h50 + k, k[0], 32'h550 + k);
    end
    cyc(); pop_hold = 1'b0; put(0, 32'h54, 1'b1, 32'h554);
    @(negedge CLK);
    chk("full_ready", 32'(req_ready), 0); chk("full_count", 32'(count), 4);
    chk("full_upd", 32'(update_btb), 1);
    cyc();
    @(negedge CLK);
    chk("resume_ready", 32'(req_ready), 32'h1); chk("resume_count", 32'(count), 3);
    expect_upd(32'h54, 1'b1, 32'h554);
    cyc(); req_valid = 2'b00;
    @(negedge CLK); chk("resume_count2", 32'(count), 3);
    repeat (3) cyc();
    @(negedge CLK); chk("drain_count", 32'(count), 0); chk("drain_upd", 32'(update_btb), 0);

    // flush three queued entries; none may ever appear
    for (int k = 0; k < 3; k++) begin
      cyc(); pop_hold = 1'b1; put(0, 32'h600 + k, 1'b1, 32'h6600 + k); req_valid = 2'b01;
      @(negedge CLK); chk("pref_ready", 32'(req_ready), 32'h1);
    end
    cyc(); pop_hold = 1'b0; flush = 1'b1; req_valid = 2'b11;
    @(negedge CLK);
    chk("flush_upd", 32'(update_btb), 0); chk("flush_ready", 32'(req_ready), 0);
    chk("flush_count", 32'(count), 3);
    cyc(); flush = 1'b0; put(0, 32'h70, 1'b0, 32'h770); put(1, 32'h71, 1'b1, 32'h771);
    @(negedge CLK);
    chk("postflush_count", 32'(count), 0); chk("postflush_upd", 32'(update_btb), 0);
    chk("postflush_ready", 32'(req_ready), 32'h2);
    expect_upd(32'h71, 1'b1, 32'h771);
    cyc(); req_valid = 2'b00;
    @(negedge CLK); chk("postflush_emit", 32'(update_btb), 1);

    // reset mid-operation with two queued and both requesting
    for (int k = 0; k < 2; k++) begin
      cyc(); pop_hold = 1'b1; put(0, 32'h800 + k, 1'b0, 32'h8800 + k); req_valid = 2'b01;
      @(negedge CLK); chk("prerst_ready", 32'(req_ready), 32'h1);
    end
    cyc(); RST = 1'b1; req_valid = 2'b11;
    @(negedge CLK); chk("prerst_count", 32'(count), 2);
    cyc(); RST = 1'b0; pop_hold = 1'b0;
    put(0, 32'h90, 1'b1, 32'h990); put(1, 32'h91, 1'b0, 32'h991);
    @(negedge CLK);
    chk("mrst_count", 32'(count), 0); chk("mrst_upd", 32'(update_btb), 0);
    chk("mrst_ptr_ready", 32'(req_ready), 32'h1);
    expect_upd(32'h90, 1'b1, 32'h990);
    cyc(); req_valid = 2'b00;
    @(negedge CLK); chk("mrst_count1", 32'(count), 1);
    repeat (3) cyc();
    @(negedge CLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btb_update_arbiter.md
BTB_UPDATE_ARBITER -- requirements
Module: btb_update_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of branch-resolution requesters (fixed at 2 for this revision).
REQ-002 SHALL have parameter DEPTH, default 4, update-queue entries (power of 2).
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports named as follows.
REQ-004 CLK  input  1  clock; all state changes on rising edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 req_valid  input  [NREQ]  requester i holds a resolved branch.
REQ-007 req_pc  input  [NREQ] x word_t  PC of resolved branch.
REQ-008 req_outcome  input  [NREQ]  1 = taken.
REQ-009 req_target  input  [NREQ] x word_t  resolved target.
REQ-010 req_ready  output  [NREQ]  grant; the transfer occurs when valid && ready in the same cycle.
REQ-011 flush  input  1  discard all queued updates.
REQ-012 update_btb  output  1  drives the BTB update strobe.
REQ-013 update_pc, branch_target  output  word_t each  drive the BTB update fields.
REQ-014 branch_outcome  output  1  drives the BTB outcome field.
REQ-015 count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-016 SHALL accept at most one request per cycle, chosen by a round-robin arbiter among the valid requesters.
REQ-017 Arbiter: a priority pointer favours requester rr_ptr; after a grant, rr_ptr SHALL point to the other requester; with no grant, rr_ptr SHALL be unchanged.
REQ-018 req_ready[i] SHALL be 1 only for the granted requester, and only when count < DEPTH and flush == 0; ready is combinational from valid, rr_ptr, count and flush.
REQ-019 An accepted request SHALL be written to the queue tail at the next edge with {pc, outcome, target}.
REQ-020 When count > 0, update_btb SHALL be 1 and update_pc, branch_outcome and branch_target SHALL present the head entry; the BTB accepts every cycle, so the head pops each cycle update_btb == 1.
REQ-021 Latency: a request accepted in cycle N into an empty queue SHALL appear on the update port in cycle N+1; there is no combinational bypass.
REQ-022 When count == 0, update_btb SHALL be 0 and the update data outputs SHALL be 0.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-024 Full (count == DEPTH): all req_ready SHALL be 0, and the pop proceeds; acceptance resumes in the next cycle.
REQ-025 flush == 1: update_btb SHALL be 0 and all req_ready SHALL be 0 in that cycle; count and the pointers SHALL be 0 at the next edge; rr_ptr SHALL be unchanged.
REQ-026 Order: updates SHALL reach the BTB in acceptance order; duplicate PCs are not coalesced.
REQ-027 count SHALL never exceed DEPTH, and no pop SHALL occur when count == 0.

Reset
REQ-028 RST == 1 at an edge SHALL set count, head, tail and rr_ptr to 0; update_btb SHALL then read 0.
REQ-029 Reset asserted mid-operation SHALL discard queued entries without emitting them, and acceptance in the reset cycle SHALL be ignored.
REQ-030 RST SHALL take priority over flush, and flush SHALL take priority over push/pop.

Structure
REQ-031 word_t SHALL come from cpu_types, and btb_upd_t (pc, outcome, target) SHALL be added to cpu_types.
REQ-032 The round-robin grant logic SHALL be a sub-module rr_arbiter (NREQ parameter, req vector in, one-hot grant out, advance input).
REQ-033 The queue storage SHALL be inline registers, with no memory macro.

Verification
REQ-034 Reset, then req_valid=2'b01, pc=0x100, taken, target=0x200 for 1 cycle -> next cycle update_btb=1, update_pc=0x100, branch_outcome=1, branch_target=0x200; the cycle after, update_btb=0.
REQ-035 Both requesters valid for 4 cycles (pc 0x10 on req0, 0x20 on req1) -> grants alternate 0,1,0,1 and the BTB sees 0x10,0x20,0x10,0x20 in order.
REQ-036 Hold update consumption at one per cycle while pushing 5 requests, then block the pop by check -> count peaks at 1 with steady one-in-one-out; with count forced to 4 via back-to-back pushes under flush-free stall (prefill through the stalled-pop test hook), req_ready=0 and the 5th request waits one cycle.
REQ-037 Queue holding 3 entries, flush=1 for 1 cycle -> update_btb=0 in that cycle, count=0 the next cycle, and no queued PC ever appears.
REQ-038 RST asserted while count=2 and req_valid=2'b11 -> after the edge, count=0, update_btb=0, rr_ptr=0, and neither request is recorded.
REQ-039 Only req1 valid for 3 cycles -> req_ready[1]=1 every cycle despite rr_ptr, with no starvation and no idle cycle.
